// File: rtl/dff_resp_checker_if.sv
// Signal bundle between a D flip-flop stimulus/observation point and its response checker.
// The checker takes the slave side; whoever drives the DUT stimulus takes the master side.
interface dff_resp_checker_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             stim_d;
    logic             dut_rst_n;
    logic             dut_q;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_idx;

    modport master (
        output start, num_samples, stim_d, dut_rst_n, dut_q,
        input  busy, done, pass, fail, sample_cnt, err_cnt, first_err_idx
    );

    modport slave (
        input  start, num_samples, stim_d, dut_rst_n, dut_q,
        output busy, done, pass, fail, sample_cnt, err_cnt, first_err_idx
    );
endinterface

// File: rtl/dff_resp_checker.sv
// Response checker for a LAT-cycle D flip-flop: predicts q through a reference pipeline,
// compares every CHECK cycle, counts samples/mismatches and reports pass/fail.
module dff_resp_checker #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    dff_resp_checker_if.slave bus
);
    localparam int unsigned FILL_W = 3;

    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

    state_t             state, state_next;
    logic [LAT-1:0]     exp_pipe;
    logic [LAT-1:0]     exp_shift;
    logic               expected;
    logic               mismatch;
    logic [FILL_W-1:0]  fill_cnt, fill_next;
    logic [CNT_W-1:0]   target, target_next;
    logic [CNT_W-1:0]   sample_cnt, sample_next;
    logic [CNT_W-1:0]   err_cnt, err_next;
    logic [CNT_W-1:0]   first_err_idx, first_next;
    logic               fail, fail_next;
    logic               busy, done, pass;

    if (LAT == 1) begin : g_shift1
        assign exp_shift = bus.stim_d;
    end else begin : g_shiftn
        assign exp_shift = {exp_pipe[LAT-2:0], bus.stim_d};
    end

    // Reference pipeline runs in every state; a low DUT reset flushes it to zero.
    always_ff @(posedge clk) begin
        if (reset || !bus.dut_rst_n) begin
            exp_pipe <= '0;
        end else begin
            exp_pipe <= exp_shift;
        end
    end

    assign expected = bus.dut_rst_n ? exp_pipe[LAT-1] : 1'b0;
    assign mismatch = (bus.dut_q !== expected);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        fill_next   = fill_cnt;
        target_next = target;
        sample_next = sample_cnt;
        err_next    = err_cnt;
        first_next  = first_err_idx;
        fail_next   = fail;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next  = FILL;
                    fill_next   = '0;
                    target_next = (bus.num_samples == '0) ? CNT_W'(1) : bus.num_samples;
                    sample_next = '0;
                    err_next    = '0;
                    first_next  = '0;
                    fail_next   = 1'b0;
                end
            end
            FILL: begin
                if (fill_cnt == FILL_W'(LAT - 1)) begin
                    state_next = CHECK;
                end else begin
                    fill_next = fill_cnt + FILL_W'(1);
                end
            end
            CHECK: begin
                sample_next = sample_cnt + CNT_W'(1);
                if (mismatch) begin
                    fail_next = 1'b1;
                    if (err_cnt != '1) begin
                        err_next = err_cnt + CNT_W'(1);
                    end
                    if (!fail) begin
                        first_next = sample_cnt;
                    end
                end
                if (sample_next == target) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status flags follow the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt      <= '0;
            target        <= '0;
            sample_cnt    <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            fail          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            fill_cnt      <= fill_next;
            target        <= target_next;
            sample_cnt    <= sample_next;
            err_cnt       <= err_next;
            first_err_idx <= first_next;
            fail          <= fail_next;
            busy          <= (state_next == FILL) || (state_next == CHECK);
            done          <= (state_next == DONE);
            pass          <= (state_next == DONE) && (err_next == '0);
        end
    end

    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.pass          = pass;
    assign bus.fail          = fail;
    assign bus.sample_cnt    = sample_cnt;
    assign bus.err_cnt       = err_cnt;
    assign bus.first_err_idx = first_err_idx;
endmodule
